sub32_seq: RTL and testbench



---
 rtl/sub32_seq.sv | 173 +++++++++++++++++
 tb/tb_sub32_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub32_seq.sv
// sub32_seq: multi-cycle 32-bit subtractor, d = a - b computed as a + ~b + 1,
// one nibble per clock over eight clocks with the carry held between nibbles.
// Optional build macro SUB32_SEQ_FLAGS_EN: when defined, the zero (z) and
// signed-overflow (v) flags are computed and registered; when undefined both
// outputs are tied low and the flag logic is not built.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; result outputs hold the last result
// RUN    | one nibble of A + ~B + c per clock, k = nibble index 0..7

module sub32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] d,
  output logic        bo,
  output logic        z,
  output logic        v
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [2:0]  r_k;
  logic        r_c;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_p;
  logic        r_done;
  logic [31:0] r_d;
  logic        r_bo;

  logic        w_accept;
  logic        w_run;
  logic        w_last;
  logic [4:0]  w_bit_base;
  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [4:0]  w_sum;
  logic [31:0] w_d_final;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_run      = (r_state == S_RUN);
  assign w_last     = w_run && (r_k == 3'd7);
  assign w_bit_base = {r_k, 2'b00};

  // Select the active nibble of each operand.
  assign w_a_nib = r_a[w_bit_base +: 4];
  assign w_b_nib = r_b[w_bit_base +: 4];

  // One nibble of the ripple: A + ~B + carry-in, carry out in bit 4.
  assign w_sum = {1'b0, w_a_nib} + {1'b0, ~w_b_nib} + {4'b0000, r_c};

  // The last nibble is still in flight on the final cycle, so splice it in.
  assign w_d_final = {w_sum[3:0], r_p[27:0]};

  // Control FSM: IDLE -> RUN on an accepted start, back after nibble 7.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (r_k == 3'd7) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Nibble index: restarts at 0 on accept, advances once per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k <= 3'd0;
    end else if (w_accept) begin
      r_k <= 3'd0;
    end else if (w_run) begin
      r_k <= r_k + 3'd1;
    end
  end

  // Carry between nibbles; seeded with 1 to form the two's complement of B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c <= 1'b0;
    end else if (w_accept) begin
      r_c <= 1'b1;
    end else if (w_run) begin
      r_c <= w_sum[4];
    end
  end

  // Operand capture; start is ignored while RUN so operands stay frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= 32'h0;
      r_b <= 32'h0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Partial result, filled one nibble per RUN cycle from the bottom up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p <= 32'h0;
    end else if (w_accept) begin
      r_p <= 32'h0;
    end else if (w_run) begin
      r_p[w_bit_base +: 4] <= w_sum[3:0];
    end
  end

  // Result registers update only on the final nibble and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d  <= 32'h0;
      r_bo <= 1'b0;
    end else if (w_last) begin
      r_d  <= w_d_final;
      r_bo <= ~w_sum[4];
    end
  end

  // Done is a single-cycle pulse coinciding with the result update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

`ifdef SUB32_SEQ_FLAGS_EN
  logic r_z;
  logic r_v;
  logic w_z_next;
  logic w_v_next;

  // Overflow: operand signs differ and the result sign departs from A.
  assign w_z_next = (w_d_final == 32'h0);
  assign w_v_next = (r_a[31] != r_b[31]) && (w_d_final[31] != r_a[31]);

  // Flag registers follow the same update rule as the difference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z <= 1'b0;
      r_v <= 1'b0;
    end else if (w_last) begin
      r_z <= w_z_next;
      r_v <= w_v_next;
    end
  end

  assign z = r_z;
  assign v = r_v;
`else
  assign z = 1'b0;
  assign v = 1'b0;
`endif

  assign busy = w_run;
  assign done = r_done;
  assign d    = r_d;
  assign bo   = r_bo;

endmodule

// File: tb/tb_sub32_seq.sv
// Bench for sub32_seq: a cycle-level reference built from plain arithmetic
// (a - b, unsigned compare, wide signed subtract) plus an 8-cycle latency
// counter, compared against the DUT every cycle, with literal spot values.

module tb_sub32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        bo;
  logic        z;
  logic        v;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  sub32_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .z     (z),
    .v     (v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference result of a - b from the arithmetic definition.
  function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rd, output logic rbo,
                                  output logic rz, output logic rv);
    longint sd;
    sd  = longint'($signed(x)) - longint'($signed(y));
    rd  = x - y;
    rbo = (x < y);
`ifdef SUB32_SEQ_FLAGS_EN
    rz  = (rd == 32'h0);
    rv  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
`else
    rz  = 1'b0;
    rv  = 1'b0;
`endif
  endfunction

  // Model: a start seen while idle arms an 8-cycle countdown; at zero the
  // precomputed result is published with a one-cycle done.
  int          m_cnt = 0;
  logic        m_done = 0;
  logic [31:0] m_d = 0;
  logic        m_bo = 0, m_z = 0, m_v = 0;
  logic [31:0] p_d = 0;
  logic        p_bo = 0, p_z = 0, p_v = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_done = 0; m_d = 0; m_bo = 0; m_z = 0; m_v = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1; m_d = p_d; m_bo = p_bo; m_z = p_z; m_v = p_v;
        end
      end else if (start) begin
        m_cnt = 8;
        ref_sub(a, b, p_d, p_bo, p_z, p_v);
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
      check("cyc_done", {31'b0, done}, {31'b0, m_done});
      check("cyc_d",    d,             m_d);
      check("cyc_bo",   {31'b0, bo},   {31'b0, m_bo});
      check("cyc_z",    {31'b0, z},    {31'b0, m_z});
      check("cyc_v",    {31'b0, v},    {31'b0, m_v});
    end
  end

  // One start pulse, then wait (bounded) for done; reports latency and
  // the number of sampled cycles with busy high.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] od, output logic obo,
                        output logic oz, output logic ov,
                        output int lat, output int bcnt);
    bit got;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    bcnt = busy ? 1 : 0;
    @(negedge clk);
    start = 1'b0; a = $urandom(); b = $urandom();
    lat = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1;
      else if (busy) bcnt++;
    end
    if (!got) check("done_timeout", {31'b0, done}, 32'h1);
    od = d; obo = bo; oz = z; ov = v;
  endtask

  logic [31:0] rd, ed;
  logic        rbo, rz, rv, ebo, ez, ev;
  int          lat, bcnt, t1, t2, seen;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_d",    d,             32'h0);
    check("rst_bo",   {31'b0, bo},   32'h0);
    check("rst_z",    {31'b0, z},    32'h0);
    check("rst_v",    {31'b0, v},    32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);

    run_op(32'd5, 32'd3, rd, rbo, rz, rv, lat, bcnt);
    check("t1_lat",  lat,            32'd8);
    check("t1_busy", bcnt,           32'd8);
    check("t1_d",    rd,             32'h2);
    check("t1_bo",   {31'b0, rbo},   32'h0);
    check("t1_z",    {31'b0, rz},    32'h0);
    check("t1_v",    {31'b0, rv},    32'h0);

    run_op(32'd3, 32'd5, rd, rbo, rz, rv, lat, bcnt);
    check("t2_d",  rd,           32'hFFFFFFFE);
    check("t2_bo", {31'b0, rbo}, 32'h1);
    check("t2_v",  {31'b0, rv},  32'h0);

    run_op(32'h80000000, 32'h1, rd, rbo, rz, rv, lat, bcnt);
    check("t3_d",  rd,           32'h7FFFFFFF);
    check("t3_bo", {31'b0, rbo}, 32'h0);
`ifdef SUB32_SEQ_FLAGS_EN
    check("t3_v",  {31'b0, rv},  32'h1);
`else
    check("t3_v",  {31'b0, rv},  32'h0);
`endif

    run_op(32'h12345678, 32'h12345678, rd, rbo, rz, rv, lat, bcnt);
    check("t4_d",  rd,           32'h0);
    check("t4_bo", {31'b0, rbo}, 32'h0);
`ifdef SUB32_SEQ_FLAGS_EN
    check("t4_z",  {31'b0, rz},  32'h1);
`else
    check("t4_z",  {31'b0, rz},  32'h0);
`endif
    check("t4_v",  {31'b0, rv},  32'h0);

    // Re-pulse at T3 with different operands must be ignored.
    @(negedge clk);
    a = 32'd10; b = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    check("hold_d_during_run", d, 32'h0);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("repulse_done", seen, 32'd1);
    check("repulse_d",    d,    32'd6);
    repeat (3) @(posedge clk);

    // Start held continuously: completions 9 cycles apart.
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      @(posedge clk);
      #1;
      if (done) t1 = cyc;
    end
    for (int i = 0; i < 30 && t2 < 0; i++) begin
      @(posedge clk);
      #1;
      if (done) t2 = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b_seen",   {31'b0, (t1 >= 0 && t2 >= 0)}, 32'h1);
    check("b2b_period", t2 - t1, 32'd9);
    check("b2b_d",      d,       32'd93);
    repeat (3) @(posedge clk);

    // Asynchronous reset between edges aborts the in-flight operation.
    @(negedge clk);
    a = 32'hDEAD0000; b = 32'h0000BEEF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    check("arst_d",    d,             32'h0);
    check("arst_bo",   {31'b0, bo},   32'h0);
    check("arst_z",    {31'b0, z},    32'h0);
    check("arst_v",    {31'b0, v},    32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("abort_no_done", seen, 32'h0);

    run_op(32'h00001000, 32'h00000001, rd, rbo, rz, rv, lat, bcnt);
    check("post_rst_d",  rd,           32'h00000FFF);
    check("post_rst_bo", {31'b0, rbo}, 32'h0);

    // Randomised operands mixed with corner values.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0: begin ra = $urandom(); rb = ra; end
        1: begin ra = 32'h80000000; rb = $urandom(); end
        2: begin ra = $urandom(); rb = 32'hFFFFFFFF; end
        3: begin ra = 32'h7FFFFFFF; rb = 32'h80000000 | $urandom(); end
        default: begin ra = $urandom(); rb = $urandom(); end
      endcase
      run_op(ra, rb, rd, rbo, rz, rv, lat, bcnt);
      ref_sub(ra, rb, ed, ebo, ez, ev);
      check("rnd_lat", lat,          32'd8);
      check("rnd_d",   rd,           ed);
      check("rnd_bo",  {31'b0, rbo}, {31'b0, ebo});
      check("rnd_z",   {31'b0, rz},  {31'b0, ez});
      check("rnd_v",   {31'b0, rv},  {31'b0, ev});
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
